// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
// Two masters share one peripheral bus. Master 0 is the CPU load/store unit and
// master 1 is debug/DMA. At most one transaction is in flight at a time.
//
// When both masters request in the same cycle, the grant goes to the master
// that was not granted last. A request to an unmapped address is answered with
// an error straight away and never reaches the bus. A transaction that waits
// too long on the slave is ended with an error.
//
// Ports
//   i_clk, i_rst_n                 clock; asynchronous active-low reset
//   i_mN_req/we/addr/wdata/bmask   master N request and attributes (N = 0, 1)
//   o_mN_ack/err/rdata             master N one-cycle completion strobe,
//                                  error flag and read data
//   o_bus_valid                    transaction active on the peripheral bus
//   o_bus_addr/wdata/we/bmask      latched transaction attributes
//   i_bus_ready, i_bus_rdata       slave completion and read data
// -----------------------------------------------------------------------------
module io_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_bmask,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_bmask,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,
  output logic        o_bus_valid,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_bmask,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Wait count value of the last BUS cycle allowed before an error completion.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        last_m1_q;   // 1: master 1 was granted most recently
  logic        gnt_m1_q;    // owner of the transaction in flight
  logic [7:0]  wait_q;
  logic        bus_valid_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic        bus_we_q;
  logic [3:0]  bus_bmask_q;
  logic        m0_ack_q;
  logic        m0_err_q;
  logic [31:0] m0_rdata_q;
  logic        m1_ack_q;
  logic        m1_err_q;
  logic [31:0] m1_rdata_q;

  logic        any_req_s;
  logic        win_m1_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_bmask_s;
  logic        sel_mapped_s;
  logic        resp_fire_s;
  logic        resp_m1_s;
  logic        resp_err_s;
  logic [31:0] resp_rdata_s;

  // Address decode of the three mapped peripheral windows.
  function automatic logic addr_mapped(input logic [31:0] a);
    logic low_win;
    logic mid_win;
    logic high_win;
    low_win  = (a[31:11] == 21'd0);
    mid_win  = (a[31:16] == 16'h1000) && (a[15:0] <= 16'h4FFF);
    high_win = (a[31:12] == 20'h10010);
    return low_win || mid_win || high_win;
  endfunction

  // Arbitration: a lone requester always wins, a tie goes to the master not granted last.
  always_comb begin
    any_req_s = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) begin
      win_m1_s = ~last_m1_q;
    end else begin
      win_m1_s = i_m1_req;
    end
    if (win_m1_s) begin
      sel_we_s    = i_m1_we;
      sel_addr_s  = i_m1_addr;
      sel_wdata_s = i_m1_wdata;
      sel_bmask_s = i_m1_bmask;
    end else begin
      sel_we_s    = i_m0_we;
      sel_addr_s  = i_m0_addr;
      sel_wdata_s = i_m0_wdata;
      sel_bmask_s = i_m0_bmask;
    end
    sel_mapped_s = addr_mapped(sel_addr_s);
  end

  // Completion decode: which master gets a response next cycle, and with what.
  always_comb begin
    resp_fire_s  = 1'b0;
    resp_m1_s    = gnt_m1_q;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s && !sel_mapped_s) begin
          resp_fire_s = 1'b1;
          resp_m1_s   = win_m1_s;
          resp_err_s  = 1'b1;
        end else begin
          resp_fire_s = 1'b0;
        end
      end
      ST_BUS: begin
        // Ready wins over a timeout that would fire in the same cycle.
        if (i_bus_ready) begin
          resp_fire_s  = 1'b1;
          resp_rdata_s = bus_we_q ? 32'd0 : i_bus_rdata;
        end else if (wait_q == WAIT_LAST) begin
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
        end else begin
          resp_fire_s = 1'b0;
        end
      end
      default: begin
        resp_fire_s = 1'b0;
      end
    endcase
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      last_m1_q   <= 1'b1;
      gnt_m1_q    <= 1'b0;
      wait_q      <= 8'd0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_we_q    <= 1'b0;
      bus_bmask_q <= 4'd0;
      m0_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m1_ack_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m1_rdata_q  <= 32'd0;
    end else begin
      m0_ack_q   <= resp_fire_s & ~resp_m1_s;
      m0_err_q   <= resp_fire_s & ~resp_m1_s & resp_err_s;
      m0_rdata_q <= (resp_fire_s && !resp_m1_s) ? resp_rdata_s : 32'd0;
      m1_ack_q   <= resp_fire_s & resp_m1_s;
      m1_err_q   <= resp_fire_s & resp_m1_s & resp_err_s;
      m1_rdata_q <= (resp_fire_s && resp_m1_s) ? resp_rdata_s : 32'd0;
      case (state_q)
        ST_IDLE: begin
          if (any_req_s) begin
            gnt_m1_q    <= win_m1_s;
            last_m1_q   <= win_m1_s;
            bus_addr_q  <= sel_addr_s;
            bus_wdata_q <= sel_wdata_s;
            bus_we_q    <= sel_we_s;
            bus_bmask_q <= sel_bmask_s;
            wait_q      <= 8'd0;
            if (sel_mapped_s) begin
              state_q     <= ST_BUS;
              bus_valid_q <= 1'b1;
            end else begin
              state_q <= ST_RESP;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (resp_fire_s) begin
            state_q     <= ST_RESP;
            bus_valid_q <= 1'b0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          bus_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_m0_ack    = m0_ack_q;
  assign o_m0_err    = m0_err_q;
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m1_ack    = m1_ack_q;
  assign o_m1_err    = m1_err_q;
  assign o_m1_rdata  = m1_rdata_q;
  assign o_bus_valid = bus_valid_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_bmask = bus_bmask_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
// Self-checking bench for io_bus_arbiter: a transaction-level reference model
// predicts every output each cycle, and directed transactions carry
// hand-computed latency / error / data expectations.
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_bmask, m1_bmask;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_bmask;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // slave behaviour: ready in the ready_at-th bus cycle (0 = never)
  int sl_cnt = 0;
  int ready_at = 0;

  io_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .i_m0_bmask(m0_bmask),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .i_m1_bmask(m1_bmask),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
    .o_bus_valid(bus_valid), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .o_bus_we(bus_we), .o_bus_bmask(bus_bmask),
    .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          in_bus = 1'b0, in_resp = 1'b0, cur_m1 = 1'b0, last_m1 = 1'b1;
  int          bus_cycles = 0;
  logic        e_bv = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0;
  logic [3:0]  e_bmask = 4'd0;
  logic        e_ack0 = 1'b0, e_ack1 = 1'b0, e_err0 = 1'b0, e_err1 = 1'b0;
  logic [31:0] e_rd0 = 32'd0, e_rd1 = 32'd0;

  function automatic bit in_map(input logic [31:0] a);
    return (a <= 32'h0000_07FF) ||
           (a >= 32'h1000_0000 && a <= 32'h1000_4FFF) ||
           (a >= 32'h1001_0000 && a <= 32'h1001_0FFF);
  endfunction

  task automatic finish_txn(input logic err, input logic [31:0] rd);
    in_bus = 1'b0;
    in_resp = 1'b1;
    e_bv = 1'b0;
    if (cur_m1) begin
      e_ack1 = 1'b1; e_err1 = err; e_rd1 = rd;
    end else begin
      e_ack0 = 1'b1; e_err0 = err; e_rd0 = rd;
    end
  endtask

  task automatic model_step();
    bit m;
    if (!rst_n) begin
      in_bus = 1'b0; in_resp = 1'b0; last_m1 = 1'b1; cur_m1 = 1'b0;
      e_bv = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_bmask = 4'd0;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      e_rd0 = 32'd0; e_rd1 = 32'd0;
    end else begin
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      e_rd0 = 32'd0; e_rd1 = 32'd0;
      if (in_resp) begin
        in_resp = 1'b0;
      end else if (in_bus) begin
        bus_cycles++;
        if (bus_ready) finish_txn(1'b0, e_we ? 32'd0 : bus_rdata);
        else if (bus_cycles == TMO) finish_txn(1'b1, 32'd0);
      end else if (m0_req || m1_req) begin
        m = (m0_req && m1_req) ? !last_m1 : m1_req;
        last_m1 = m;
        cur_m1 = m;
        e_addr  = m ? m1_addr  : m0_addr;
        e_wdata = m ? m1_wdata : m0_wdata;
        e_we    = m ? m1_we    : m0_we;
        e_bmask = m ? m1_bmask : m0_bmask;
        if (in_map(e_addr)) begin
          in_bus = 1'b1; bus_cycles = 0; e_bv = 1'b1;
        end else begin
          finish_txn(1'b1, 32'd0);
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("bus_valid", bus_valid, e_bv);
    chk("bus_addr", bus_addr, e_addr);
    chk("bus_wdata", bus_wdata, e_wdata);
    chk("bus_we", bus_we, e_we);
    chk("bus_bmask", bus_bmask, e_bmask);
    chk("m0_ack", m0_ack, e_ack0);
    chk("m0_err", m0_err, e_err0);
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_ack", m1_ack, e_ack1);
    chk("m1_err", m1_err, e_err1);
    chk("m1_rdata", m1_rdata, e_rd1);
  end

  // Simple slave: asserts ready in the chosen bus cycle.
  always @(negedge clk) begin
    if (bus_valid) begin
      sl_cnt = sl_cnt + 1;
      bus_ready = (ready_at != 0) && (sl_cnt == ready_at);
    end else begin
      sl_cnt = 0;
      bus_ready = 1'b0;
    end
  end

  // ---------------- directed transactions ----------------
  task automatic txn(input string name, input bit m, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] bmask, input int rdy, input logic [31:0] rdat,
                     input bit drop_early, input int exp_lat, input logic exp_err,
                     input logic [31:0] exp_rd, input int exp_bv);
    int c0, bv, lat;
    bit got;
    logic err;
    logic [31:0] rd;
    @(negedge clk);
    ready_at = rdy;
    bus_rdata = rdat;
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_bmask = bmask;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_bmask = bmask;
    end
    c0 = cyc; got = 1'b0; bv = 0; lat = -1; err = 1'b0; rd = 32'd0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (drop_early) begin
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
      end
      if (bus_valid) bv++;
      if (m ? m1_ack : m0_ack) begin
        got = 1'b1;
        lat = cyc - c0;
        err = m ? m1_err : m0_err;
        rd  = m ? m1_rdata : m0_rdata;
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
      end
    end
    chk({name, "_acked"}, {31'd0, got}, 32'd1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_bus_cycles"}, bv, exp_bv);
  endtask

  // Both masters hold requests; grants must alternate starting with expected master.
  task automatic contest(input string name, input bit first_m1);
    int order[4];
    int n, overlap;
    @(negedge clk);
    ready_at = 1;
    bus_rdata = 32'h0BAD_F00D;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0010; m0_wdata = 32'h0; m0_bmask = 4'hF;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1001_0020; m1_wdata = 32'h5555_AAAA; m1_bmask = 4'h3;
    n = 0; overlap = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) overlap++;
      if (m0_ack) begin order[n] = 0; n++; end
      else if (m1_ack) begin order[n] = 1; n++; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk({name, "_count"}, n, 4);
    chk({name, "_overlap"}, overlap, 0);
    for (int k = 0; k < n; k++)
      chk({name, "_grant"}, order[k], (k % 2) ^ int'(first_m1));
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_bmask = 4'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_bmask = 4'd0;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_bus_valid", bus_valid, 32'd0);
    chk("reset_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;

    // first contest after reset: m0 first, then alternate
    contest("rr_after_reset", 1'b0);
    // single m1 write to unmapped space: immediate error, bus never used
    txn("unmapped_m1_wr", 1'b1, 1'b1, 32'h2000_0000, 32'h1111_2222, 4'hF, 1, 32'h0,
        1'b0, 1, 1'b1, 32'd0, 0);
    // minimum latency mapped read
    txn("m0_rd_min", 1'b0, 1'b0, 32'h1001_0000, 32'h0, 4'hF, 1, 32'hA5A5_0001,
        1'b0, 2, 1'b0, 32'hA5A5_0001, 1);
    @(negedge clk);
    chk("bus_addr_hold", bus_addr, 32'h1001_0000);
    // region boundaries
    txn("edge_low_out", 1'b0, 1'b0, 32'h0000_0800, 32'h0, 4'h1, 1, 32'h77,
        1'b0, 1, 1'b1, 32'd0, 0);
    txn("edge_mid_out", 1'b1, 1'b0, 32'h1000_5000, 32'h0, 4'h2, 1, 32'h77,
        1'b0, 1, 1'b1, 32'd0, 0);
    txn("edge_high_in", 1'b1, 1'b0, 32'h1001_0FFF, 32'h0, 4'h8, 2, 32'h3C3C_0FFF,
        1'b0, 3, 1'b0, 32'h3C3C_0FFF, 2);
    // timeout: never ready
    txn("timeout", 1'b0, 1'b0, 32'h1000_4000, 32'h0, 4'hF, 0, 32'hFFFF_FFFF,
        1'b0, 17, 1'b1, 32'd0, 16);
    // ready in the last allowed bus cycle beats the timeout
    txn("ready_at_limit", 1'b1, 1'b0, 32'h1000_4FFC, 32'h0, 4'hC, 16, 32'hCAFE_F00D,
        1'b0, 17, 1'b0, 32'hCAFE_F00D, 16);
    // request dropped mid-transaction still gets its ack
    txn("dropped_req", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 3, 32'h1234_5678,
        1'b1, 4, 1'b0, 32'h1234_5678, 3);

    // reset in the middle of a bus wait
    @(negedge clk);
    ready_at = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0100; m0_wdata = 32'h0; m0_bmask = 4'hF;
    repeat (5) @(negedge clk);
    chk("pre_reset_bus_valid", bus_valid, 32'd1);
    rst_n = 1'b0;
    m0_req = 1'b0;
    #1;
    chk("midbus_reset_bus_valid", bus_valid, 32'd0);
    chk("midbus_reset_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // write returns zero rdata even though the slave drives data
    txn("post_reset_wr", 1'b0, 1'b1, 32'h0000_07FC, 32'h89AB_CDEF, 4'h6, 1, 32'hDEAD_BEEF,
        1'b0, 2, 1'b0, 32'd0, 1);
    // last grant was m0, so m1 wins the next contest
    contest("rr_after_m0", 1'b1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
